// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the RV32I core and a handshaked data bus.
// Ports: core side (MemRead/MemWrite/LdStrSrc/Addr/WData -> Stall/LdData/LdValid/
//   MisalignExc/BusErrExc), bus side (bus_req/we/addr/be/wdata -> bus_rdata/ack/err).
module lsu_ctrl #(
  parameter  int TIMEOUT = 16,
  localparam int TO_W    = $clog2(TIMEOUT) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  LdStrSrc,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Stall,
  output logic [31:0] LdData,
  output logic        LdValid,
  output logic        MisalignExc,
  output logic        BusErrExc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  a_q, a_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;
  logic        berr_q, berr_d;

  logic        acc, illegal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_ext;
  logic        to_hit, err_now;

  always_comb begin
    acc = MemRead | MemWrite;

    illegal = 1'b1;
    case (LdStrSrc)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = Addr[0];
      3'b010:  illegal = |Addr[1:0];
      3'b100:  illegal = MemWrite;
      3'b101:  illegal = MemWrite | Addr[0];
      default: illegal = 1'b1;
    endcase

    be_new    = 4'hf;
    wdata_new = WData;
    unique case (1'b1)
      LdStrSrc[1:0] == 2'b00: begin
        be_new    = 4'b0001 << Addr[1:0];
        wdata_new = {4{WData[7:0]}};
      end
      LdStrSrc[1:0] == 2'b01: begin
        be_new    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{WData[15:0]}};
      end
      default: begin
        be_new    = 4'hf;
        wdata_new = WData;
      end
    endcase

    shifted = bus_rdata >> {a_q, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = a_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_ext = {{16{half_v[15]}}, half_v};
      3'b100:  ld_ext = {24'd0, byte_v};
      3'b101:  ld_ext = {16'd0, half_v};
      default: ld_ext = bus_rdata;
    endcase

    // An ack on the final timeout cycle still completes; err always wins.
    to_hit  = cnt_q == TO_W'(TIMEOUT - 1);
    err_now = bus_err | (to_hit & ~bus_ack);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    a_d        = a_q;
    f3_d       = f3_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    berr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && !illegal) begin
          we_d    = MemWrite;
          addr_d  = {Addr[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          a_d     = Addr[1:0];
          f3_d    = LdStrSrc;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (err_now) begin
          berr_d  = 1'b1;
          state_d = DONE;
        end else if (bus_ack) begin
          if (!we_q) ld_data_d = ld_ext;
          ld_valid_d = ~we_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      a_q        <= '0;
      f3_q       <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      a_q        <= a_d;
      f3_q       <= f3_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      berr_q     <= berr_d;
    end
  end

  // Stall is gated by reset so the core is released the moment reset hits.
  assign Stall = ~reset &
    (((state_q == IDLE) & acc & ~illegal) | (state_q == REQ));
  assign MisalignExc = (state_q == IDLE) & acc & illegal;
  assign bus_req   = state_q == REQ;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign LdData    = ld_data_q;
  assign LdValid   = ld_valid_q;
  assign BusErrExc = berr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl.
// Acts as bus responder; expected bus fields and results are queued at drive time.
module tb_lsu_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  LdStrSrc = '0;
  logic [31:0] Addr = '0, WData = '0;
  logic        Stall, LdValid, MisalignExc, BusErrExc;
  logic [31:0] LdData;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0, bus_err = 1'b0;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .LdStrSrc(LdStrSrc), .Addr(Addr), .WData(WData),
    .Stall(Stall), .LdData(LdData), .LdValid(LdValid),
    .MisalignExc(MisalignExc), .BusErrExc(BusErrExc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  typedef struct {
    bit          err;
    logic [31:0] data;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] last_ld = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [2:0] f3,
                                        input logic [31:0] a);
    case (f3[1:0])
      2'b00: case (a[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
      2'b01: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3,
                                         input logic [31:0] w);
    case (f3[1:0])
      2'b00: return {w[7:0], w[7:0], w[7:0], w[7:0]};
      2'b01: return {w[15:0], w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = r[7:0];
      2'd1: b = r[15:8];
      2'd2: b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b001: return {{16{h[15]}}, h};
      3'b100: return {24'd0, b};
      3'b101: return {16'd0, h};
      default: return r;
    endcase
  endfunction

  // Monitor: bus fields on request start, results on LdValid/BusErrExc.
  logic prev_req = 1'b0;
  initial forever begin
    @(negedge clk);
    if (bus_req && !prev_req) begin
      if (bus_q.size() == 0) chk("bus_unexp", 32'd1, 32'd0);
      else begin
        bus_t e;
        e = bus_q.pop_front();
        chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
        chk("bus_addr", bus_addr, e.addr);
        chk("bus_be", {28'd0, bus_be}, {28'd0, e.be});
        if (e.we) chk("bus_wdata", bus_wdata, e.wd);
      end
    end
    prev_req = bus_req;
    if (LdValid || BusErrExc) begin
      if (res_q.size() == 0) chk("res_unexp", {LdValid, BusErrExc}, 0);
      else begin
        res_t r;
        r = res_q.pop_front();
        chk("res_kind", {30'd0, LdValid, BusErrExc},
            r.err ? 32'd1 : 32'd2);
        if (!r.err) chk("ld_data", LdData, r.data);
      end
    end
  end

  // mode: 0 ack, 1 err, 2 ack+err same cycle, 3 no response (timeout)
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdata, input int k,
                        input int mode);
    bus_t b;
    res_t r;
    int req_n = 0, stall_n = 0, cyc = 0;
    bit done = 0;
    b.we = wr; b.addr = {a[31:2], 2'b00};
    b.be = exp_be(f3, a); b.wd = exp_wd(f3, wd);
    bus_q.push_back(b);
    if (mode != 0) begin
      r.err = 1; r.data = '0; res_q.push_back(r);
    end else if (rd) begin
      r.err = 0; r.data = exp_ld(f3, a, rdata); res_q.push_back(r);
      last_ld = r.data;
    end
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; LdStrSrc = f3; Addr = a; WData = wd;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (Stall) stall_n++;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
      if (bus_req) begin
        req_n++;
        if (req_n == k && mode != 3) begin
          bus_ack   = (mode == 0 || mode == 2);
          bus_err   = (mode == 1 || mode == 2);
          bus_rdata = rdata;
        end
      end else if (req_n > 0) done = 1;
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    MemRead = 0; MemWrite = 0;
    chk("stall_cycles", stall_n, (mode == 3 ? TO : k) + 1);
    chk("req_cycles", req_n, mode == 3 ? TO : k);
  endtask

  task automatic bad(input bit rd, input bit wr, input logic [2:0] f3,
                     input logic [31:0] a);
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; LdStrSrc = f3; Addr = a;
    @(negedge clk);
    chk("mis_exc", {31'd0, MisalignExc}, 32'd1);
    chk("mis_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    chk("mis_hold", {31'd0, MisalignExc}, 32'd1);
    MemRead = 0; MemWrite = 0;
    @(negedge clk);
    chk("mis_clear", {31'd0, MisalignExc}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_lddata", LdData, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_flags", {LdValid, BusErrExc, bus_we}, 32'd0);
    @(posedge clk); #1 reset = 0;

    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 0);
    access(1, 0, 3'b000, 32'h103, 0, 32'h80FF_FFFF, 1, 0);
    access(1, 0, 3'b100, 32'h103, 0, 32'h80FF_FFFF, 2, 0);
    access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 2, 0);
    access(0, 1, 3'b000, 32'h101, 32'h0000005A, 0, 1, 0);
    access(0, 1, 3'b010, 32'h200, 32'hCAFEF00D, 0, 4, 0);
    access(1, 0, 3'b001, 32'h102, 0, 32'h8001_7FFF, 1, 0);
    access(1, 0, 3'b101, 32'h100, 0, 32'h8001_F00F, 2, 0);
    access(1, 0, 3'b000, 32'h101, 0, 32'h1234_7F00, 1, 0);

    bad(1, 0, 3'b010, 32'h101);
    bad(1, 0, 3'b011, 32'h100);
    bad(1, 0, 3'b001, 32'h103);
    bad(0, 1, 3'b100, 32'h100);
    bad(1, 0, 3'b110, 32'h100);

    access(1, 0, 3'b010, 32'h300, 0, 32'h11111111, 2, 1);
    chk("ld_hold_err", LdData, last_ld);
    access(1, 0, 3'b010, 32'h304, 0, 32'h22222222, 1, 2);
    chk("ld_hold_both", LdData, last_ld);
    access(0, 1, 3'b010, 32'h308, 32'h33333333, 0, 1, 1);
    access(1, 0, 3'b010, 32'h30C, 0, 0, 0, 3);
    chk("ld_hold_to", LdData, last_ld);
    access(1, 0, 3'b010, 32'h310, 0, 32'h5555AAAA, TO, 0);

    begin
      bus_t b;
      b.we = 0; b.addr = 32'h400; b.be = 4'hf; b.wd = '0;
      bus_q.push_back(b);
      @(posedge clk); #1;
      MemRead = 1; LdStrSrc = 3'b010; Addr = 32'h400;
      repeat (3) @(negedge clk);
      chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
      #2 reset = 1;
      #1;
      chk("async_req", {31'd0, bus_req}, 32'd0);
      chk("async_stall", {31'd0, Stall}, 32'd0);
      @(negedge clk);
      MemRead = 0;
      @(posedge clk); #1 reset = 0;
    end
    access(1, 0, 3'b001, 32'h402, 0, 32'hF00D_0123, 2, 0);

    repeat (3) @(negedge clk);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
